// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Provides wb_sel_t source encoding and load funct3 codes.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_p_if.sv
// MEM->WB bundle plus register-file write port and retire count.
// Modports: master (MEM side / driver), slave (writeback stage).
interface wb_stage_p_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              in_valid;
  logic              stall;
  logic              flush;
  logic              reg_write;
  logic [REG_AW-1:0] rd_addr;
  logic [1:0]        wb_sel;
  logic [XLEN-1:0]   alu_data;
  logic [XLEN-1:0]   mem_data;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   imm_data;
  logic [2:0]        funct3;
  logic [1:0]        byte_off;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output in_valid, stall, flush,
    output reg_write, rd_addr, wb_sel,
    output alu_data, mem_data,
    output pc_plus4, imm_data,
    output funct3, byte_off,
    input  rf_we, rf_waddr, rf_wdata,
    input  retire_cnt
  );

  modport slave (
    input  in_valid, stall, flush,
    input  reg_write, rd_addr, wb_sel,
    input  alu_data, mem_data,
    input  pc_plus4, imm_data,
    input  funct3, byte_off,
    output rf_we, rf_waddr, rf_wdata,
    output retire_cnt
  );

endinterface

// File: rtl/wb_load_fmt.sv
// Combinational sub-word load aligner / extender.
// In: mem_data, funct3, byte_off. Out: fmt_data.
module wb_load_fmt
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  output logic [XLEN-1:0] fmt_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_data[8*byte_off +: 8];
    lane_h = byte_off[1] ? mem_data[31:16]
                         : mem_data[15:0];
  end

  always_comb begin
    fmt_data = mem_data;
    unique case (1'b1)
      (funct3 == F3_LB):
        fmt_data = {{(XLEN-8){lane_b[7]}}, lane_b};
      (funct3 == F3_LBU):
        fmt_data = {{(XLEN-8){1'b0}}, lane_b};
      (funct3 == F3_LH):
        fmt_data = {{(XLEN-16){lane_h[15]}}, lane_h};
      (funct3 == F3_LHU):
        fmt_data = {{(XLEN-16){1'b0}}, lane_h};
      default:
        fmt_data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// Registered writeback stage: source select, x0 gating, retire count.
// Ports: clk, rst (sync, active-high), bus (wb_stage_p_if.slave).
// Optional WB_LOAD_EXT_EN enables sub-word load formatting.
module wb_stage_p
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_stage_p_if.slave     bus
);

  logic [XLEN-1:0]   mem_fmt;
  logic [XLEN-1:0]   sel_data;
  logic              we_nxt;
  logic              retire;
  logic              we_q;
  logic [REG_AW-1:0] waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [CNT_W-1:0]  cnt_q;

`ifdef WB_LOAD_EXT_EN
  wb_load_fmt #(
    .XLEN (XLEN)
  ) u_fmt (
    .mem_data (bus.mem_data),
    .funct3   (bus.funct3),
    .byte_off (bus.byte_off),
    .fmt_data (mem_fmt)
  );
`else
  logic unused_fmt;
  assign unused_fmt = ^{bus.funct3, bus.byte_off};
  assign mem_fmt = bus.mem_data;
`endif

  always_comb begin
    sel_data = bus.alu_data;
    unique case (wb_sel_t'(bus.wb_sel))
      WB_ALU:  sel_data = bus.alu_data;
      WB_MEM:  sel_data = mem_fmt;
      WB_PC4:  sel_data = bus.pc_plus4;
      WB_IMM:  sel_data = bus.imm_data;
      default: sel_data = bus.alu_data;
    endcase
  end

  assign we_nxt = bus.in_valid
                & bus.reg_write
                & (|bus.rd_addr);

  assign retire = bus.in_valid
                & ~bus.stall
                & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (bus.flush) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (bus.stall) begin
      we_q    <= 1'b0;
    end else begin
      we_q    <= we_nxt;
      waddr_q <= bus.rd_addr;
      wdata_q <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (retire)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.rf_we      = we_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.retire_cnt = cnt_q;

endmodule
